// File: rtl/present80_key_schedule_if.sv
// Round-key handshake bundle between the key schedule (slave) and the round datapath / controller (master).
// The master drives start, key_in and rk_ready. The slave returns the round key and its status.
interface present80_key_schedule_if;
   logic        start;
   logic [79:0] key_in;
   logic [63:0] round_key;
   logic        rk_valid;
   logic        rk_ready;
   logic [5:0]  round_idx;
   logic        busy;
   logic        done;

   modport master (
      output start, key_in, rk_ready,
      input  round_key, rk_valid, round_idx, busy, done
   );

   modport slave (
      input  start, key_in, rk_ready,
      output round_key, rk_valid, round_idx, busy, done
   );
endinterface

// File: rtl/present80_key_schedule.sv
// PRESENT-80 round-key generator: emits K1..K32, one per accepted valid/ready transfer; first key 1 cycle after start.
// Backpressure: while rk_ready is low, key_reg and round_idx hold, so round_key stays stable.
module present80_key_schedule #(
   parameter int NUM_RK = 32,
   parameter int RC_LSB = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   present80_key_schedule_if.slave      ks
);
   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [5:0] IDX_LAST = 6'(NUM_RK);

   state_t      r_state;
   logic [79:0] r_key;
   logic [5:0]  r_idx;
   logic        r_done;

   state_t      w_state_nxt;
   logic [79:0] w_key_nxt;
   logic [5:0]  w_idx_nxt;
   logic        w_done_nxt;
   logic [79:0] w_key_rot;
   logic [79:0] w_key_upd;
   logic        w_xfer;

   function automatic logic [3:0] f_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   assign w_key_rot = {r_key[18:0], r_key[79:19]};

   // Rotate, substitute the top nibble, then fold in the counter of the key just consumed.
   always_comb begin
      w_key_upd                = w_key_rot;
      w_key_upd[79:76]         = f_sbox(w_key_rot[79:76]);
      w_key_upd[RC_LSB +: 5]   = w_key_rot[RC_LSB +: 5] ^ r_idx[4:0];
   end

   assign w_xfer = (r_state == ACTIVE) && ks.rk_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (ks.start) begin
               w_state_nxt = ACTIVE;
               w_key_nxt   = ks.key_in;
               w_idx_nxt   = 6'd1;
            end
         end
         ACTIVE: begin
            if (w_xfer) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = IDLE;
                  w_idx_nxt   = 6'd0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_key_nxt   = w_key_upd;
                  w_idx_nxt   = r_idx + 6'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ks.round_key = r_key[79:16];
   assign ks.rk_valid  = (r_state == ACTIVE);
   assign ks.busy      = (r_state == ACTIVE);
   assign ks.round_idx = r_idx;
   assign ks.done      = r_done;
endmodule

// File: tb/tb_present80_key_schedule.sv
// Bench for present80_key_schedule: random keys and backpressure checked against a PRESENT-80 reference model.
module tb_present80_key_schedule;
   logic clk;
   logic rst_n;

   present80_key_schedule_if ks ();

   present80_key_schedule #(.NUM_RK(32), .RC_LSB(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ks    (ks)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [3:0]  SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   logic [63:0] rk_model [1:32];
   logic [63:0] got_rk   [1:32];
   int          done_cyc;

   task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [79:0] ks_next(input logic [79:0] k, input int i);
      logic [79:0] t;
      t = (k << 61) | (k >> 19);
      t[79:76] = SB[t[79:76]];
      t = t ^ (80'(i) << 15);
      return t;
   endfunction

   task automatic fill_model(input logic [79:0] key);
      logic [79:0] k;
      k = key;
      for (int i = 1; i <= 32; i++) begin
         rk_model[i] = k[79:16];
         k = ks_next(k, i);
      end
   endtask

   function automatic logic [63:0] encrypt(input logic [63:0] pt);
      logic [63:0] s, sb, p;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ got_rk[r];
         for (int n = 0; n < 16; n++) sb[n*4 +: 4] = SB[s[n*4 +: 4]];
         for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (b * 16) % 63] = sb[b];
         s = p;
      end
      return s ^ got_rk[32];
   endfunction

   // Runs one schedule from the current negedge. pre: start already asserted by the caller.
   task automatic run_sched(input logic [79:0] key, input int rdy_pct, input int hold_at,
                            input int poke_at, input bit pre, input bit chain,
                            input logic [79:0] chain_key);
      int n, cyc;
      bit held, seen_done;
      fill_model(key);
      if (!pre) begin
         ks.start  = 1'b1;
         ks.key_in = key;
      end
      ks.rk_ready = 1'b0;
      @(negedge clk);
      ks.start = 1'b0;
      chk("first_valid", 80'(ks.rk_valid), 80'(1));
      chk("first_idx", 80'(ks.round_idx), 80'(1));
      chk("done_one_cycle", 80'(ks.done), 80'(0));
      n = 0; cyc = 0; held = 0; seen_done = 0;
      while (!seen_done && cyc < 400) begin
         if (ks.done) begin
            seen_done = 1;
            done_cyc  = cyc;
            if (chain) begin
               ks.start  = 1'b1;
               ks.key_in = chain_key;
            end
         end else begin
            if (ks.rk_valid) begin
               chk("busy", 80'(ks.busy), 80'(1));
               if (hold_at != 0 && int'(ks.round_idx) == hold_at && !held) begin
                  ks.rk_ready = 1'b0;
                  repeat (5) begin
                     @(negedge clk);
                     chk("hold_key", 80'(ks.round_key), 80'(rk_model[hold_at]));
                     chk("hold_idx", 80'(ks.round_idx), 80'(hold_at));
                  end
                  held = 1;
               end
               if (poke_at != 0 && int'(ks.round_idx) == poke_at) begin
                  ks.start  = 1'b1;
                  ks.key_in = ~key;
               end
               ks.rk_ready = ($urandom_range(1, 100) <= rdy_pct);
               if (ks.rk_ready) begin
                  n++;
                  chk("idx", 80'(ks.round_idx), 80'(n));
                  chk("rk", 80'(ks.round_key), 80'(rk_model[(n > 32) ? 32 : n]));
                  if (n <= 32) got_rk[n] = ks.round_key;
               end
            end
            @(negedge clk);
            ks.start = 1'b0;
            cyc++;
         end
      end
      if (!seen_done) chk("done_timeout", 80'(0), 80'(1));
      chk("n_keys", 80'(n), 80'(32));
      ks.rk_ready = 1'b0;
      if (!chain) begin
         @(negedge clk);
         chk("post_done", 80'(ks.done), 80'(0));
         chk("post_valid", 80'(ks.rk_valid), 80'(0));
         chk("post_idx", 80'(ks.round_idx), 80'(0));
         chk("post_key_kept", 80'(ks.round_key), 80'(rk_model[32]));
      end
   endtask

   initial begin
      logic [79:0] rkey, bkey;
      int guard;
      rst_n = 1'b0;
      ks.start = 1'b0;
      ks.key_in = '0;
      ks.rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 80'(ks.rk_valid), 80'(0));
      chk("rst_busy", 80'(ks.busy), 80'(0));
      chk("rst_done", 80'(ks.done), 80'(0));
      chk("rst_idx", 80'(ks.round_idx), 80'(0));
      chk("rst_key", 80'(ks.round_key), 80'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Zero key, ready always high: golden keys, done latency, ciphertext.
      run_sched(80'h0, 100, 0, 0, 0, 0, 80'h0);
      chk("zk_K1", 80'(got_rk[1]), 80'(64'h0000000000000000));
      chk("zk_K2", 80'(got_rk[2]), 80'(64'hC000000000000000));
      chk("zk_K3", 80'(got_rk[3]), 80'(64'h5000180000000001));
      chk("zk_done_lat", 80'(done_cyc), 80'(32));
      chk("ct_zero", 80'(encrypt(64'h0)), 80'(64'h5579C1387B228445));

      rkey = '1;
      run_sched(rkey, 100, 0, 0, 0, 0, 80'h0);
      chk("ct_ones", 80'(encrypt(64'h0)), 80'(64'hE72C46C0F5945049));

      // Backpressure at round 2 and start ignored mid-schedule.
      run_sched(80'h0, 100, 2, 0, 0, 0, 80'h0);
      chk("bp_K2", 80'(got_rk[2]), 80'(64'hC000000000000000));
      chk("bp_K3", 80'(got_rk[3]), 80'(64'h5000180000000001));
      run_sched(80'h0, 100, 0, 10, 0, 0, 80'h0);
      chk("poke_done_lat", 80'(done_cyc), 80'(32));

      // Back-to-back schedules chained through the done cycle.
      bkey = {$urandom, $urandom, 16'($urandom)};
      run_sched(80'h0, 100, 0, 0, 0, 1, bkey);
      run_sched(bkey, 100, 0, 0, 1, 0, 80'h0);
      chk("b2b_K1", 80'(got_rk[1]), 80'(bkey[79:16]));

      // Random keys under random backpressure.
      for (int r = 0; r < 4; r++) begin
         rkey = {$urandom, $urandom, 16'($urandom)};
         run_sched(rkey, 60, 0, 0, 0, 0, 80'h0);
      end

      // Asynchronous reset in the middle of a schedule.
      ks.start = 1'b1;
      ks.key_in = 80'h0;
      @(negedge clk);
      ks.start = 1'b0;
      ks.rk_ready = 1'b1;
      guard = 0;
      while (ks.round_idx != 6'd17 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("reach_idx17", 80'(ks.round_idx), 80'(17));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 80'(ks.rk_valid), 80'(0));
      chk("arst_busy", 80'(ks.busy), 80'(0));
      chk("arst_done", 80'(ks.done), 80'(0));
      chk("arst_idx", 80'(ks.round_idx), 80'(0));
      ks.rk_ready = 1'b0;
      @(negedge clk);
      chk("arst_no_done", 80'(ks.done), 80'(0));
      rst_n = 1'b1;
      @(negedge clk);
      rkey = {$urandom, $urandom, 16'($urandom)};
      run_sched(rkey, 100, 0, 0, 0, 0, 80'h0);
      chk("arst_K1", 80'(got_rk[1]), 80'(rkey[79:16]));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/present80_key_schedule.md
Name: present80_key_schedule

Overview:
- Round-key generator for the round-based, area-optimised PRESENT-80 core.
- Holds the 80-bit key register and applies the PRESENT-80 key update once per accepted round key.
- On start, the register selects key_in (load path); on each update, it selects the updated key. This is the 2:1 80-bit select feeding the register, implemented internally.
- Emits K1..K32 one at a time to the round datapath under a valid/ready handshake.

Parameters:
- NUM_RK, 32, number of round keys emitted (K1..K32, K32 = post-whitening key); counter width fixed at 6 bits.
- RC_LSB, 15, bit position of the LSB of the 5-bit round-counter XOR field (k[19:15]).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
- key_in  in  80  user key, sampled on the accepted start cycle
- round_key  out  64  current round key = key_reg[79:16]
- rk_valid  out  1  round_key is valid
- rk_ready  in  1  consumer accepts round_key this cycle
- round_idx  out  6  index of the presented round key, 1..32; 0 in IDLE
- busy  out  1  high in ACTIVE
- done  out  1  one-cycle pulse after K32 is accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - key_reg = 0, round_idx = 0, state = IDLE.
  - rk_valid = 0, busy = 0, done = 0, round_key = 0.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - rk_valid = 0, busy = 0.
  - start = 1 -> next cycle: key_reg = key_in, round_idx = 1, state = ACTIVE.
  - Latency from start to first rk_valid is 1 cycle.
- ACTIVE:
  - rk_valid = 1, busy = 1.
  - round_key is combinational from key_reg[79:16] and is stable while rk_valid && !rk_ready.
- Transfer = rk_valid && rk_ready.
  - On a transfer with round_idx < 32, key_reg is updated in one cycle, in this order on the old value k:
    1. t = {k[18:0], k[79:19]} (rotate left by 61).
    2. t[79:76] = S(t[79:76]), where S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
    3. t[19:15] ^= round_idx[4:0].
  - After the update, key_reg = t and round_idx += 1. rk_valid stays high, so back-to-back transfers sustain one key per cycle.
  - On a transfer with round_idx == 32: no key update; state = IDLE, round_idx = 0, rk_valid = 0 next cycle, and done = 1 for exactly that one cycle.
- While rk_ready is low: key_reg and round_idx hold. There is no timeout.
- start in ACTIVE is ignored; there is no restart or abort. The only abort is reset.
- start in the same cycle that done is high (state IDLE) is accepted normally, giving a back-to-back schedule.
- Reset asserted mid-schedule: all outputs drop to their reset values immediately (asynchronously). No done pulse is issued.
- key_reg is left unchanged after K32. It is overwritten only by the next accepted start or by reset.
- S-box is an inline combinational 16-entry lookup; no other arithmetic. round_idx never exceeds 32.

Test Plan:
- Zero key, rk_ready tied high: start with key_in = 0 -> K1 = 0000000000000000, K2 = C000000000000000, K3 = 5000180000000001 on consecutive cycles. round_idx = 1, 2, 3. done pulses exactly 32 cycles after the first rk_valid.
- Full run into a reference PRESENT-80 datapath model, key 0 and plaintext 0 -> ciphertext 5579C1387B228445. Repeat with key FFFFFFFFFFFFFFFFFFFF and plaintext 0 -> E72C46C0F5945049.
- Backpressure: drop rk_ready for 5 cycles while round_idx = 2 -> round_key holds C000000000000000 and round_idx holds 2. Resuming yields K3 = 5000180000000001 with no key skipped or duplicated.
- Start ignored when busy: pulse start with a different key_in while round_idx = 10 -> sequence unaffected and matches the golden zero-key K10..K32.
- Back-to-back schedules: assert start in the done cycle -> next cycle rk_valid = 1, round_idx = 1, K1 = new key_in[79:16].
- Reset mid-run: deassert rst_n at round_idx = 17 -> rk_valid, busy, done and round_idx go to 0 without waiting for a clock. After release, a new start produces the correct K1.
